arm_flag_unit: RTL and testbench

Condition/flag unit on the execute stage of the ARM datapath, on the consumer side of the ALU. It holds the architectural NZCV flags and feeds the C flag back to the ALU carry input. Each cycle it evaluates the 4-bit ARM condition of the instruction in execute, then writes back the flags the ALU produced. Results go to writeback through a one-entry valid/ready output register.

---
 rtl/arm_flag_unit.sv | 105 ++++++++++
 tb/tb_arm_flag_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/arm_flag_unit.sv
// NZCV flag unit for the ARM execute stage: evaluates the condition, updates the flags
// and passes per-instruction results to writeback through a one-entry output register.
module arm_flag_unit #(
   parameter logic [3:0] FLAG_RESET = 4'b0000,
   parameter int         CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [3:0]           cond,
   input  logic [3:0]           alu_op,
   input  logic                 s_bit,
   input  logic                 shifter_carry,
   input  logic                 alu_n,
   input  logic                 alu_z,
   input  logic                 alu_c,
   input  logic                 alu_v,
   output logic                 alu_cin,
   input  logic                 flag_wr,
   input  logic [3:0]           flag_wdata,
   output logic [3:0]           flags,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_exec,
   output logic                 out_wb,
   output logic [3:0]           out_flags,
   output logic [CNT_WIDTH-1:0] skip_cnt
);

   logic       accept;
   logic       pass;
   logic       is_test;
   logic       is_arith;
   logic       fn, fz, fc, fv;
   logic [3:0] nxt_flags;

   assign {fn, fz, fc, fv} = flags;
   assign alu_cin  = fc;
   assign in_ready = (!out_valid || out_ready) && !flag_wr;
   assign accept   = in_valid && in_ready;
   assign is_test  = (alu_op[3:2] == 2'b10);
   assign is_arith = alu_op inside {[4'd2:4'd7], 4'd10, 4'd11};

   always_comb begin
      pass = 1'b0;
      case (cond)
         4'd0:    pass = fz;
         4'd1:    pass = !fz;
         4'd2:    pass = fc;
         4'd3:    pass = !fc;
         4'd4:    pass = fn;
         4'd5:    pass = !fn;
         4'd6:    pass = fv;
         4'd7:    pass = !fv;
         4'd8:    pass = fc && !fz;
         4'd9:    pass = !fc || fz;
         4'd10:   pass = (fn == fv);
         4'd11:   pass = (fn != fv);
         4'd12:   pass = !fz && (fn == fv);
         4'd13:   pass = fz || (fn != fv);
         4'd14:   pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

   // Logical ops take C from the shifter and never touch V.
   always_comb begin
      nxt_flags = flags;
      if (pass && (s_bit || is_test)) begin
         if (is_arith) nxt_flags = {alu_n, alu_z, alu_c, alu_v};
         else          nxt_flags = {alu_n, alu_z, shifter_carry, fv};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       flags <= FLAG_RESET;
      else if (flag_wr) flags <= flag_wdata;
      else if (accept)  flags <= nxt_flags;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_exec  <= 1'b0;
         out_wb    <= 1'b0;
         out_flags <= 4'b0000;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_exec  <= pass;
         out_wb    <= pass && !is_test;
         out_flags <= nxt_flags;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         skip_cnt <= '0;
      else if (accept && !pass && (skip_cnt != {CNT_WIDTH{1'b1}}))
         skip_cnt <= skip_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   end

endmodule

// File: tb/tb_arm_flag_unit.sv
// Directed and random checks of arm_flag_unit against a flag/condition reference model.
module tb_arm_flag_unit;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid, in_ready;
   logic [3:0]    cond, alu_op;
   logic          s_bit, shifter_carry, alu_n, alu_z, alu_c, alu_v, alu_cin;
   logic          flag_wr;
   logic [3:0]    flag_wdata, flags;
   logic          out_valid, out_ready, out_exec, out_wb;
   logic [3:0]    out_flags;
   logic [CW-1:0] skip_cnt;

   int checks = 0;
   int errors = 0;

   // reference state
   bit          mn, mz, mc, mv;
   bit          mov, mexec, mwb;
   bit [3:0]    mof;
   int unsigned mskip;

   arm_flag_unit #(.FLAG_RESET(4'b0000), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .cond(cond), .alu_op(alu_op), .s_bit(s_bit), .shifter_carry(shifter_carry),
      .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .alu_cin(alu_cin),
      .flag_wr(flag_wr), .flag_wdata(flag_wdata), .flags(flags),
      .out_valid(out_valid), .out_ready(out_ready), .out_exec(out_exec),
      .out_wb(out_wb), .out_flags(out_flags), .skip_cnt(skip_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit cond_ok(input int c, input bit n, input bit z, input bit cf, input bit v);
      case (c)
         0: return z;          1: return !z;
         2: return cf;         3: return !cf;
         4: return n;          5: return !n;
         6: return v;          7: return !v;
         8: return cf && !z;   9: return !cf || z;
         10: return n == v;    11: return n != v;
         12: return !z && (n == v);
         13: return z || (n != v);
         14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      {mn, mz, mc, mv} = 4'b0000;
      mov = 0; mexec = 0; mwb = 0; mof = 4'b0000; mskip = 0;
   endtask

   task automatic check_outputs(input string pfx);
      chk({pfx, "_flags"}, flags, {mn, mz, mc, mv});
      chk({pfx, "_out_valid"}, out_valid, mov);
      chk({pfx, "_out_exec"}, out_exec, mexec);
      chk({pfx, "_out_wb"}, out_wb, mwb);
      chk({pfx, "_out_flags"}, out_flags, mof);
      chk({pfx, "_skip_cnt"}, skip_cnt, mskip);
   endtask

   // Called 1 time unit after a rising edge with inputs already driven.
   task automatic cyc(input string pfx);
      bit rdy, acc, pass, arith, test;
      bit [3:0] nf;
      #1;
      rdy = (!mov || out_ready) && !flag_wr;
      chk({pfx, "_in_ready"}, in_ready, rdy);
      chk({pfx, "_alu_cin"}, alu_cin, mc);
      acc   = in_valid && rdy;
      pass  = cond_ok(int'(cond), mn, mz, mc, mv);
      test  = (alu_op >= 8 && alu_op <= 11);
      arith = (alu_op >= 2 && alu_op <= 7) || alu_op == 10 || alu_op == 11;
      nf = {mn, mz, mc, mv};
      if (pass && (s_bit || test))
         nf = arith ? {alu_n, alu_z, alu_c, alu_v} : {alu_n, alu_z, shifter_carry, mv};
      @(posedge clk);
      #1;
      if (flag_wr) {mn, mz, mc, mv} = flag_wdata;
      else if (acc) {mn, mz, mc, mv} = nf;
      if (acc) begin
         mov = 1; mexec = pass; mwb = pass && !test; mof = nf;
         if (!pass && mskip < (1 << CW) - 1) mskip++;
      end else if (mov && out_ready) mov = 0;
      check_outputs(pfx);
   endtask

   task automatic instr(input bit [3:0] c, input bit [3:0] op, input bit s,
                        input bit [3:0] nzcv, input bit sc);
      in_valid = 1; cond = c; alu_op = op; s_bit = s;
      {alu_n, alu_z, alu_c, alu_v} = nzcv; shifter_carry = sc;
   endtask

   initial begin
      rst_n = 0; in_valid = 0; cond = 0; alu_op = 0; s_bit = 0; shifter_carry = 0;
      {alu_n, alu_z, alu_c, alu_v} = 4'b0000; flag_wr = 0; flag_wdata = 0; out_ready = 1;
      model_reset();
      #3;
      check_outputs("reset");
      chk("reset_alu_cin", alu_cin, 1'b0);
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;

      // ADDS 1 + -1 -> Z and C set
      instr(4'd14, 4'd4, 1, 4'b0110, 0); cyc("adds");
      chk("adds_exp_flags", flags, 4'b0110);
      chk("adds_exp_exec", out_exec, 1'b1);
      chk("adds_exp_cin", alu_cin, 1'b1);

      // CMP sets Z, then MOVEQ / MOVNE back-to-back
      instr(4'd14, 4'd10, 0, 4'b0110, 0); cyc("cmp");
      instr(4'd0, 4'd13, 0, 4'b1000, 1); cyc("moveq");
      chk("moveq_exp_wb", out_wb, 1'b1);
      instr(4'd1, 4'd13, 0, 4'b1000, 1); cyc("movne");
      chk("movne_exp_exec", out_exec, 1'b0);
      chk("movne_exp_skip", skip_cnt, 1);
      chk("movne_exp_flags", flags, 4'b0110);

      // logical flag rule: V kept, C from shifter
      in_valid = 0; flag_wr = 1; flag_wdata = 4'b0001; cyc("msr1");
      flag_wr = 0;
      instr(4'd14, 4'd0, 1, 4'b1000, 1); cyc("ands");
      chk("ands_exp_flags", flags, 4'b1011);

      // backpressure
      out_ready = 0;
      instr(4'd14, 4'd13, 0, 4'b0000, 0); cyc("bp_acc");
      instr(4'd14, 4'd4, 1, 4'b1001, 0);
      for (int i = 0; i < 3; i++) begin
         cyc("bp_hold");
         chk("bp_exp_hold_ready", in_ready, 1'b0);
      end
      out_ready = 1; cyc("bp_drain");
      chk("bp_exp_flags", flags, 4'b1001);

      // direct write stalls issue; GE passes next cycle
      flag_wr = 1; flag_wdata = 4'b1001;
      instr(4'd10, 4'd13, 0, 4'b0000, 0); cyc("msr2");
      chk("msr2_exp_flags", flags, 4'b1001);
      flag_wr = 0; cyc("ge");
      chk("ge_exp_exec", out_exec, 1'b1);

      // NV never executes; saturate the skip counter
      instr(4'd15, 4'd11, 1, 4'b0110, 1); cyc("nv_cmn");
      chk("nv_exp_flags", flags, 4'b1001);
      for (int i = 0; i < (1 << CW) + 2; i++) cyc("nv_sat");
      chk("sat_exp_skip", skip_cnt, (1 << CW) - 1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         flag_wr = ($urandom_range(0, 7) == 0);
         flag_wdata = 4'($urandom);
         cond = 4'($urandom); alu_op = 4'($urandom); s_bit = 1'($urandom);
         shifter_carry = 1'($urandom);
         {alu_n, alu_z, alu_c, alu_v} = 4'($urandom);
         cyc("rand");
      end

      // reset mid-transfer drops the pending entry
      flag_wr = 0; out_ready = 0;
      instr(4'd14, 4'd4, 1, 4'b1111, 0); cyc("pre_rst");
      #2 rst_n = 0;
      #1 model_reset();
      check_outputs("mid_rst");
      chk("mid_rst_exp_valid", out_valid, 1'b0);
      in_valid = 0; out_ready = 1;
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      instr(4'd14, 4'd4, 1, 4'b0010, 0); cyc("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
